// File: rtl/interp_timing_ctrl.sv
// Symbol-timing scheduler: symbol-phase accumulator on the raw strobe,
// presents symbol age as phase_int/mu over valid/ready, ages and drops.
// Ports: clk, rst (async high), enable_i, iq_raw_val_i, period_i,
//   terr_i/terr_val_i, phase_int_o, mu_o, sym_valid_o, sym_ready_i,
//   drop_cnt_o/sym_cnt_o when ITC_STATS_EN is defined.
module interp_timing_ctrl #(
    parameter int OSF    = 20,
    parameter int PIW    = 5,
    parameter int MUW    = 27,
    parameter int TERR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    input  logic                     iq_raw_val_i,
    input  logic [PIW+MUW:0]         period_i,
    input  logic signed [TERR_W-1:0] terr_i,
    input  logic                     terr_val_i,
    output logic [PIW-1:0]           phase_int_o,
    output logic [MUW-1:0]           mu_o,
    output logic                     sym_valid_o,
    input  logic                     sym_ready_i
`ifdef ITC_STATS_EN
    ,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [CNT_W-1:0]         sym_cnt_o
`endif
);

    // rem spans +/-2^(PIW+2) samples: enough for twice the largest period
    localparam int RW = PIW + MUW + 3;
    localparam int AW = PIW + MUW;
    localparam int XW = RW + 2;

    localparam logic signed [XW-1:0] RMAX = {{3{1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [XW-1:0] RMIN = {{3{1'b1}}, {(RW-1){1'b0}}};
    localparam logic signed [XW-1:0] ONE  =
        {{(XW-MUW-1){1'b0}}, 1'b1, {MUW{1'b0}}};
    localparam logic [AW-1:0] ONE_A = {{(PIW-1){1'b0}}, 1'b1, {MUW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

    state_e                 state_q, state_d;
    logic signed [RW-1:0]   rem_q, rem_d;
    logic [AW-1:0]          age_q, age_d;

    logic signed [XW-1:0]   terr_x, per_x, acc, sum;
    logic signed [RW-1:0]   rem_n, rem_ev;
    logic [AW-1:0]          age_ev;
    logic                   ev, xfer, ovf;

    function automatic logic signed [RW-1:0] sat(
        input logic signed [XW-1:0] x
    );
        if (x > RMAX) return RMAX[RW-1:0];
        if (x < RMIN) return RMIN[RW-1:0];
        return x[RW-1:0];
    endfunction

    // ceil(age) and the complementary fraction
    assign phase_int_o = age_q[AW-1:MUW] + PIW'(|age_q[MUW-1:0]);
    assign mu_o        = '0 - age_q[MUW-1:0];
    assign sym_valid_o = (state_q == PEND);

    assign xfer = sym_valid_o && sym_ready_i;
    // one more strobe of aging would push ceil(age) past OSF-1
    assign ovf  = (phase_int_o >= PIW'(OSF - 1));

    always_comb begin
        terr_x = {{(XW-TERR_W){terr_i[TERR_W-1]}}, terr_i};
        per_x  = {{(XW-PIW-MUW-1){1'b0}}, period_i};
        acc    = {{2{rem_q[RW-1]}}, rem_q};
        if (iq_raw_val_i) acc = acc - ONE;
        if (terr_val_i)   acc = acc + terr_x;
        rem_n  = sat(acc);
        sum    = {{2{rem_n[RW-1]}}, rem_n} + per_x;
        rem_ev = sat(sum);
        age_ev = AW'(-rem_n);
        ev     = iq_raw_val_i && (rem_n[RW-1] || rem_n == '0);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        age_d   = age_q;
        if (!enable_i) begin
            state_d = IDLE;
            rem_d   = '0;
            age_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rem_d   = {{(RW-PIW-MUW-1){1'b0}}, period_i};
                    state_d = RUN;
                end
                RUN: begin
                    rem_d = ev ? rem_ev : rem_n;
                    if (ev) begin
                        age_d   = age_ev;
                        state_d = PEND;
                    end
                end
                PEND: begin
                    rem_d = ev ? rem_ev : rem_n;
                    if (ev) begin
                        age_d = age_ev;
                    end else if (xfer) begin
                        state_d = RUN;
                    end else if (iq_raw_val_i) begin
                        if (ovf) state_d = RUN;
                        else     age_d   = age_q + ONE_A;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            age_q   <= age_d;
        end
    end

`ifdef ITC_STATS_EN
    logic             drop, take;
    logic [CNT_W-1:0] drop_q, sym_q;

    // drop: superseded by a new event, or aged out of the window
    assign take = enable_i && xfer;
    assign drop = enable_i && sym_valid_o && !xfer &&
                  (ev || (iq_raw_val_i && ovf));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
            sym_q  <= '0;
        end else begin
            if (drop && !(&drop_q)) drop_q <= drop_q + 1'b1;
            if (take && !(&sym_q))  sym_q  <= sym_q + 1'b1;
        end
    end

    assign drop_cnt_o = drop_q;
    assign sym_cnt_o  = sym_q;
`endif

endmodule

// File: tb/tb_interp_timing_ctrl.sv
// Directed bench for interp_timing_ctrl: vector table of symbol grids
// plus hand sequences for stall aging, drop, supersede and async reset.
module tb_interp_timing_ctrl;

    localparam int TW = 28;

    localparam logic [32:0] P20   = 33'h0_A000_0000;
    localparam logic [32:0] P2025 = 33'h0_A200_0000;
    localparam logic [TW-1:0] THALF = 28'h400_0000;
    localparam logic [TW-1:0] TMQ   = 28'hE00_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              iq = 1'b0;
    logic [32:0]       period = P20;
    logic [TW-1:0]     terr = '0;
    logic              terr_val = 1'b0;
    logic [4:0]        phase_int;
    logic [26:0]       mu;
    logic              sym_valid;
    logic              ready = 1'b1;
`ifdef ITC_STATS_EN
    logic [15:0]       drop_cnt, sym_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int exp_sym  = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    interp_timing_ctrl #(.TERR_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .iq_raw_val_i (iq),
        .period_i     (period),
        .terr_i       (terr),
        .terr_val_i   (terr_val),
        .phase_int_o  (phase_int),
        .mu_o         (mu),
        .sym_valid_o  (sym_valid),
        .sym_ready_i  (ready)
`ifdef ITC_STATS_EN
        ,
        .drop_cnt_o   (drop_cnt),
        .sym_cnt_o    (sym_cnt)
`endif
    );

    typedef struct {
        logic        rs;
        logic [32:0] per;
        int          nstr;
        int          tk;
        logic [TW-1:0] t;
        logic        ev;
        logic [4:0]  ph;
        logic [26:0] mu;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic v, input logic tv, input logic [TW-1:0] t);
        @(negedge clk);
        iq = v;
        terr_val = tv;
        terr = t;
        @(posedge clk);
        #1;
        iq = 1'b0;
        terr_val = 1'b0;
        terr = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    // one raw strobe, then three idle clocks
    task automatic strobe();
        tick(1'b1, 1'b0, '0);
        idle(3);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    task automatic restart(input logic [32:0] p);
        period = p;
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        idle(1);
    endtask

    task automatic chk_bus(input string nm, input logic v,
                           input logic [4:0] ph, input logic [26:0] m);
        chk({nm, ".valid"}, longint'(sym_valid), longint'(v));
        if (v) begin
            chk({nm, ".phase"}, longint'(phase_int), longint'(ph));
            chk({nm, ".mu"}, longint'(mu), longint'(m));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, P20,   19, 0,  '0,    1'b0, 5'd0, 27'h0};
        tbl[1]  = '{1'b0, P20,    1, 0,  '0,    1'b1, 5'd0, 27'h0};
        tbl[2]  = '{1'b0, P20,   20, 0,  '0,    1'b1, 5'd0, 27'h0};
        tbl[3]  = '{1'b1, P2025, 21, 0,  '0,    1'b1, 5'd1, 27'h200_0000};
        tbl[4]  = '{1'b0, P2025, 20, 0,  '0,    1'b1, 5'd1, 27'h400_0000};
        tbl[5]  = '{1'b0, P2025, 20, 0,  '0,    1'b1, 5'd1, 27'h600_0000};
        tbl[6]  = '{1'b0, P2025, 19, 0,  '0,    1'b0, 5'd0, 27'h0};
        tbl[7]  = '{1'b0, P2025,  1, 0,  '0,    1'b1, 5'd0, 27'h0};
        tbl[8]  = '{1'b1, P20,   21, 10, THALF, 1'b1, 5'd1, 27'h400_0000};
        tbl[9]  = '{1'b0, P20,   20, 0,  '0,    1'b1, 5'd1, 27'h400_0000};
        tbl[10] = '{1'b0, P20,   20, 5,  TMQ,   1'b1, 5'd1, 27'h200_0000};

        #12;
        chk("rst.valid", longint'(sym_valid), 0);
        chk("rst.phase", longint'(phase_int), 0);
        chk("rst.mu", longint'(mu), 0);
`ifdef ITC_STATS_EN
        chk("rst.drop_cnt", longint'(drop_cnt), 0);
        chk("rst.sym_cnt", longint'(sym_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;

        for (int r = 0; r < 11; r++) begin
            if (tbl[r].rs) restart(tbl[r].per);
            period = tbl[r].per;
            for (int s = 1; s <= tbl[r].nstr; s++) begin
                tick(1'b1, 1'b0, '0);
                if (s == tbl[r].nstr)
                    chk_bus($sformatf("vec%0d", r), tbl[r].ev,
                            tbl[r].ph, tbl[r].mu);
                idle(3);
                if (tbl[r].tk == s) tick(1'b0, 1'b1, tbl[r].t);
            end
            if (tbl[r].ev) exp_sym++;
        end

        // one-cycle pulse with ready high
        restart(P20);
        run(19);
        tick(1'b1, 1'b0, '0);
        chk_bus("pulse.on", 1'b1, 5'd0, 27'h0);
        idle(1);
        chk("pulse.off", longint'(sym_valid), 0);
        exp_sym++;
        idle(2);

        // stall for three strobes, accept at age 3
        restart(P20);
        ready = 1'b0;
        run(19);
        tick(1'b1, 1'b0, '0);
        chk_bus("stall.a0", 1'b1, 5'd0, 27'h0);
        idle(3);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 1'b0, '0);
            chk_bus($sformatf("stall.a%0d", k), 1'b1, 5'(k), 27'h0);
            idle(3);
        end
        ready = 1'b1;
        idle(1);
        chk("stall.done", longint'(sym_valid), 0);
        exp_sym++;

        // age out: event at age 0.75, dropped on the 19th stalled strobe
        restart(P2025);
        ready = 1'b0;
        run(20);
        tick(1'b1, 1'b0, '0);
        chk_bus("drop.a0", 1'b1, 5'd1, 27'h200_0000);
        idle(3);
        run(17);
        tick(1'b1, 1'b0, '0);
        chk_bus("drop.a18", 1'b1, 5'd19, 27'h200_0000);
        idle(3);
        tick(1'b1, 1'b0, '0);
        chk("drop.gone", longint'(sym_valid), 0);
        exp_drop++;
        idle(3);
        tick(1'b1, 1'b0, '0);
        chk_bus("drop.next", 1'b1, 5'd1, 27'h400_0000);
        ready = 1'b1;
        idle(1);
        chk("drop.next_acc", longint'(sym_valid), 0);
        exp_sym++;
        idle(2);

        // stalled request superseded by the next event
        restart(P20);
        ready = 1'b0;
        run(20);
        run(19);
        chk_bus("super.a19", 1'b1, 5'd19, 27'h0);
        tick(1'b1, 1'b0, '0);
        chk_bus("super.new", 1'b1, 5'd0, 27'h0);
        exp_drop++;
        ready = 1'b1;
        idle(1);
        chk("super.acc", longint'(sym_valid), 0);
        exp_sym++;
        idle(2);
`ifdef ITC_STATS_EN
        chk("stats.drop_cnt", longint'(drop_cnt), longint'(exp_drop));
        chk("stats.sym_cnt", longint'(sym_cnt), longint'(exp_sym));
`endif

        // async reset while a request is pending
        restart(P20);
        ready = 1'b0;
        run(20);
        chk("arst.pend", longint'(sym_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", longint'(sym_valid), 0);
        chk("arst.phase", longint'(phase_int), 0);
        chk("arst.mu", longint'(mu), 0);
`ifdef ITC_STATS_EN
        chk("arst.drop_cnt", longint'(drop_cnt), 0);
        chk("arst.sym_cnt", longint'(sym_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        restart(P20);
        run(19);
        tick(1'b1, 1'b0, '0);
        chk_bus("regrid", 1'b1, 5'd0, 27'h0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
